dmem_arbiter: RTL and testbench

- Arbitrates the single port of the data memory (DataMem) between two requesters:
  - the pipeline memory stage (CPU port);
  - a secondary master (AUX port), such as a DMA or debug loader.
- Sits between the memory stage and DataMem and drives the memory's address, data and write-enable.
- Applies fixed CPU priority, with an optional starvation guard that forces one AUX slot and stalls the pipeline.
- Routes the 1-cycle-latency synchronous read data back to whichever requester issued the read.

---
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DataMem port between the CPU MEM stage and an AUX master, CPU first.
// Latency: grant and port mux are combinational; read data comes back on mem_q one cycle after issue.
// Backpressure: AUX holds aux_req until aux_gnt; with DMEM_ARB_STARVE_EN a forced AUX slot raises cpu_stall.
module dmem_arbiter #(
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_en,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic [DW-1:0] cpu_rdata,
   input  logic          aux_req,
   input  logic          aux_we,
   input  logic [AW-1:0] aux_addr,
   input  logic [DW-1:0] aux_wdata,
   output logic          aux_gnt,
   output logic          aux_rvalid,
   output logic [DW-1:0] aux_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          mem_wren,
   input  logic [DW-1:0] mem_q
);

   logic aux_win;
   logic rd_aux;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
      $error("dmem_arbiter: STARVE_LIMIT must be within 1..255");
   end

`ifdef DMEM_ARB_STARVE_EN
   logic [7:0] wait_cnt;
   logic       force_aux;

   // Counts consecutive denied AUX cycles; a grant or a dropped request restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (!aux_req || aux_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != 8'(STARVE_LIMIT)) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign force_aux = aux_req && (wait_cnt == 8'(STARVE_LIMIT));
   assign aux_win   = force_aux || (!cpu_en && aux_req);
   assign cpu_stall = rst && cpu_en && aux_win;
`else
   assign aux_win   = !cpu_en && aux_req;
   assign cpu_stall = 1'b0;
`endif

   always_comb begin
      mem_addr = cpu_addr;
      mem_data = cpu_wdata;
      if (aux_win) begin
         mem_addr = aux_addr;
         mem_data = aux_wdata;
      end
   end

   // Gated by rst so nothing reaches the memory while reset is held.
   assign mem_wren = rst && (aux_win ? aux_we : (cpu_en && cpu_we));
   assign aux_gnt  = rst && aux_win;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_aux <= 1'b0;
      end else begin
         rd_aux <= aux_gnt && !aux_we;
      end
   end

   assign aux_rvalid = rd_aux;
   assign aux_rdata  = mem_q;
   assign cpu_rdata  = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural DataMem plus a reference model of the arbitration rules.
module tb_dmem_arbiter;
   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int LIM = 8;
`ifdef DMEM_ARB_STARVE_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cpu_en = 1'b0, cpu_we = 1'b0, aux_req = 1'b0, aux_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0, aux_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, aux_wdata = '0;
   logic cpu_stall, aux_gnt, aux_rvalid, mem_wren;
   logic [DW-1:0] cpu_rdata, aux_rdata, mem_data, mem_q;
   logic [AW-1:0] mem_addr;
   logic l1_stall, l1_gnt, l1_rvalid, l1_wren;
   logic [DW-1:0] l1_cpu_rdata, l1_aux_rdata, l1_data;
   logic [AW-1:0] l1_addr;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
   );

   // Second instance at the smallest legal limit, fed the same requests.
   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(1)) u_lim1 (
      .clk(clk), .rst(rst),
      .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(l1_stall), .cpu_rdata(l1_cpu_rdata),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_gnt(l1_gnt), .aux_rvalid(l1_rvalid), .aux_rdata(l1_aux_rdata),
      .mem_addr(l1_addr), .mem_data(l1_data), .mem_wren(l1_wren), .mem_q(mem_q)
   );

   logic [DW-1:0] dmem [0:65535];
   always @(posedge clk) begin
      if (mem_wren) dmem[mem_addr] <= mem_data;
      mem_q <= dmem[mem_addr];
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state: denied-streak length, pending read returns, expected memory contents.
   int            streak = 0;
   bit            pend_aux = 1'b0, pend_cpu = 1'b0;
   logic [DW-1:0] pend_dat = '0;
   logic [DW-1:0] ref_mem [int];
   bit            last_stall = 1'b0, last_gnt = 1'b0;

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return 'x;
   endfunction

   task automatic model();
      int who;
      bit forced, e_wren;
      if (!rst) begin
         chk("rst_stall", cpu_stall, 0);
         chk("rst_gnt", aux_gnt, 0);
         chk("rst_wren", mem_wren, 0);
         chk("rst_rvalid", aux_rvalid, 0);
         streak = 0; pend_aux = 0; pend_cpu = 0; last_stall = 0; last_gnt = 0;
         return;
      end
      chk("aux_rvalid", aux_rvalid, pend_aux);
      if (pend_aux) chk("aux_rdata", aux_rdata, pend_dat);
      if (pend_cpu) chk("cpu_rdata", cpu_rdata, pend_dat);
      forced = GUARD && aux_req && (streak >= LIM);
      who    = forced ? 2 : (cpu_en ? 1 : (aux_req ? 2 : 0));
      e_wren = (who == 1 && cpu_we) || (who == 2 && aux_we);
      chk("cpu_stall", cpu_stall, cpu_en && who == 2);
      chk("aux_gnt", aux_gnt, who == 2);
      chk("mem_wren", mem_wren, e_wren);
      if (who != 0) chk("mem_addr", mem_addr, (who == 1) ? cpu_addr : aux_addr);
      if (e_wren) chk("mem_data", mem_data, (who == 1) ? cpu_wdata : aux_wdata);
      pend_aux = (who == 2) && !aux_we;
      pend_cpu = (who == 1) && !cpu_we;
      if (who == 1) begin
         if (cpu_we) ref_mem[int'(cpu_addr)] = cpu_wdata; else pend_dat = ref_rd(cpu_addr);
      end else if (who == 2) begin
         if (aux_we) ref_mem[int'(aux_addr)] = aux_wdata; else pend_dat = ref_rd(aux_addr);
      end
      streak     = (aux_req && who != 2) ? ((streak < LIM) ? streak + 1 : LIM) : 0;
      last_stall = cpu_en && who == 2;
      last_gnt   = (who == 2);
   endtask

   task automatic half();
      @(negedge clk);
      model();
   endtask

   task automatic fin();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      half();
      fin();
   endtask

   task automatic idle();
      cpu_en = 0; cpu_we = 0; aux_req = 0; aux_we = 0;
   endtask

   typedef struct {
      logic          cpu_en, cpu_we;
      logic [AW-1:0] cpu_addr;
      logic [DW-1:0] cpu_wdata;
      logic          aux_req, aux_we;
      logic [AW-1:0] aux_addr;
      logic [DW-1:0] aux_wdata;
      logic          e_stall, e_gnt, e_wren;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      bit            chk_addr;
   } vec_t;

   vec_t vt [8];

   initial begin
      vt[0] = '{1, 0, 16'h0005, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0005, 16'h0000, 1};
      vt[1] = '{1, 1, 16'h0006, 16'hAAAA, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0006, 16'hAAAA, 1};
      vt[2] = '{0, 0, 16'h0001, 16'h0000, 1, 1, 16'h0007, 16'h5555, 0, 1, 1, 16'h0007, 16'h5555, 1};
      vt[3] = '{0, 1, 16'h0002, 16'h0000, 1, 0, 16'h0008, 16'h0000, 0, 1, 0, 16'h0008, 16'h0000, 1};
      vt[4] = '{1, 1, 16'h0009, 16'h1111, 1, 1, 16'h000A, 16'h2222, 0, 0, 1, 16'h0009, 16'h1111, 1};
      vt[5] = '{1, 0, 16'h000B, 16'h0000, 1, 1, 16'h000C, 16'h3333, 0, 0, 0, 16'h000B, 16'h0000, 1};
      vt[6] = '{0, 1, 16'h000D, 16'h4444, 0, 1, 16'h000E, 16'h6666, 0, 0, 0, 16'h0000, 16'h0000, 0};
      vt[7] = '{0, 0, 16'h000F, 16'h0000, 0, 1, 16'h0010, 16'h7777, 0, 0, 0, 16'h0000, 16'h0000, 0};

      // Reset with a CPU write presented: the memory must not see it.
      cpu_en = 1; cpu_we = 1; cpu_addr = 16'h0003; cpu_wdata = 16'hDEAD;
      step(); step();
      rst = 1; idle();

      // Preload 0..63 through the CPU port; 0x20 ends up holding 0x1234.
      for (int a = 0; a < 64; a++) begin
         cpu_en = 1; cpu_we = 1; cpu_addr = 16'(a); cpu_wdata = 16'h1214 + 16'(a);
         step();
      end
      idle(); step();

      // CPU store then load of the same word.
      cpu_en = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
      half(); chk("st_wren", mem_wren, 1); chk("st_data", mem_data, 16'hBEEF);
      chk("st_stall", cpu_stall, 0); fin();
      cpu_we = 0; cpu_wdata = 16'h0000;
      half(); chk("ld_wren", mem_wren, 0); chk("ld_stall", cpu_stall, 0); fin();
      idle();
      half(); chk("ld_rdata", cpu_rdata, 16'hBEEF); fin();

      // AUX read with the CPU idle.
      aux_req = 1; aux_we = 0; aux_addr = 16'h0020;
      half(); chk("auxrd_gnt", aux_gnt, 1); fin();
      idle();
      half(); chk("auxrd_rvalid", aux_rvalid, 1); chk("auxrd_rdata", aux_rdata, 16'h1234); fin();

      // Single-cycle table, each vector followed by an idle cycle.
      for (int i = 0; i < 8; i++) begin
         cpu_en = vt[i].cpu_en; cpu_we = vt[i].cpu_we; cpu_addr = vt[i].cpu_addr;
         cpu_wdata = vt[i].cpu_wdata; aux_req = vt[i].aux_req; aux_we = vt[i].aux_we;
         aux_addr = vt[i].aux_addr; aux_wdata = vt[i].aux_wdata;
         half();
         chk($sformatf("vec%0d_stall", i), cpu_stall, vt[i].e_stall);
         chk($sformatf("vec%0d_gnt", i), aux_gnt, vt[i].e_gnt);
         chk($sformatf("vec%0d_wren", i), mem_wren, vt[i].e_wren);
         if (vt[i].chk_addr) chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
         if (vt[i].e_wren) chk($sformatf("vec%0d_data", i), mem_data, vt[i].e_data);
         fin();
         idle(); step();
      end

      // Reset dropped the cycle after an AUX read grant.
      aux_req = 1; aux_we = 0; aux_addr = 16'h0020;
      half(); chk("rstrd_gnt", aux_gnt, 1); fin();
      rst = 0; cpu_en = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'hFFFF;
      #1;
      chk("rstrd_rvalid", aux_rvalid, 0);
      chk("rstrd_wren", mem_wren, 0);
      half(); fin(); step();
      rst = 1; idle(); aux_req = 1; aux_we = 0; aux_addr = 16'h0020;
      half(); chk("rstrel_gnt", aux_gnt, 1); fin();
      idle();
      half(); chk("rstrel_rdata", aux_rdata, 16'h1234); fin();

      // Saturated CPU against a persistent AUX read.
      cpu_en = 1; cpu_we = 0; cpu_addr = 16'h0003; aux_req = 1; aux_we = 0; aux_addr = 16'h0009;
      for (int c = 0; c < 100; c++) begin
         half();
         chk($sformatf("starve_gnt c%0d", c), aux_gnt, GUARD && (c % 9 == 8));
         chk($sformatf("starve_stall c%0d", c), cpu_stall, GUARD && (c % 9 == 8));
         chk($sformatf("lim1_gnt c%0d", c), l1_gnt, GUARD && (c % 2 == 1));
         chk($sformatf("lim1_stall c%0d", c), l1_stall, GUARD && (c % 2 == 1));
         fin();
      end
      idle(); step();

      // AUX request abandoned after 3 denied cycles; the next one counts from zero.
      cpu_en = 1; cpu_we = 1; cpu_addr = 16'h0011; cpu_wdata = 16'h0BAD;
      aux_req = 1; aux_we = 1; aux_addr = 16'h0012; aux_wdata = 16'hC0DE;
      for (int c = 0; c < 3; c++) begin
         half(); chk($sformatf("aband_gnt c%0d", c), aux_gnt, 0); fin();
      end
      aux_req = 0;
      half(); chk("aband_drop_gnt", aux_gnt, 0); fin();
      aux_req = 1;
      for (int c = 0; c < 10; c++) begin
         half(); chk($sformatf("recount_gnt c%0d", c), aux_gnt, GUARD && (c == 8)); fin();
      end
      idle(); step();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         if (!last_stall) begin
            cpu_en    = ($urandom_range(0, 9) < 7);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'($urandom_range(0, 63));
            cpu_wdata = 16'($urandom);
         end
         if (aux_req && !last_gnt && $urandom_range(0, 15) == 0) begin
            aux_req = 0;
         end else if (!aux_req || last_gnt) begin
            aux_req   = ($urandom_range(0, 2) == 0);
            aux_we    = 1'($urandom_range(0, 1));
            aux_addr  = 16'($urandom_range(0, 63));
            aux_wdata = 16'($urandom);
         end
         step();
      end
      idle(); step(); step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
